// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-back helpers.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 6;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // Successor index in a ring of n entries.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from rr_ptr, pointer advances past winner.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    if (en && !rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = IdxW'((32'(rr_ptr_q) + k) % N);
        if (gnt == '0 && req[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  // Any grant is a transfer: grants are only issued to valid requesters.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|gnt) rr_ptr_d = IdxW'(rr_next(32'(gnt_idx), N));
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among write-back requesters, with a registered
// output stage and forwarding compare against the pending write.
module rf_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_wa,
  output logic [DATA_W-1:0]           rf_wd,
  input  logic [ADDR_W-1:0]           chk_ra1,
  input  logic [ADDR_W-1:0]           chk_ra2,
  output logic                        fwd_hit1,
  output logic                        fwd_hit2,
  output logic [DATA_W-1:0]           fwd_data
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (wb_en),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_addr = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_data = req_data[32'(gnt_idx)*DATA_W +: DATA_W];
  end

  // Address/data hold when idle so the forwarding compare stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (|gnt) begin
      rf_we <= 1'b1;
      rf_wa <= sel_addr;
      rf_wd <= sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always_comb begin
    fwd_hit1 = rf_we && (chk_ra1 == rf_wa);
    fwd_hit2 = rf_we && (chk_ra2 == rf_wa);
    fwd_data = rf_wd;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a behavioural register file as the write sink.
module tb_rf_wb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_en;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [DW-1:0]   rf_wd;
  logic [AW-1:0]   chk_ra1, chk_ra2;
  logic            fwd_hit1, fwd_hit2;
  logic [DW-1:0]   fwd_data;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rf_mem [64];
  logic [N-1:0]  pend;
  logic [N-1:0]  rdy_s;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .chk_ra1   (chk_ra1),
    .chk_ra2   (chk_ra2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Register file sink: commits one edge after the output stage.
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;

  // Requester protocol: a pending request must not be withdrawn.
  always @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) if (pend[i]) chk($sformatf("proto%0d", i), 32'(req_valid[i]), 32'd1);
      pend <= req_valid & ~req_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  function automatic logic [31:0] ptr();
    return 32'(dut.u_arb.rr_ptr_q);
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] exp_g;
    for (int i = 0; i < 64; i++) rf_mem[i] = '0;
    rst = 1'b1; wb_en = 1'b1; req_valid = '1;
    req_addr = '0; req_data = '0; chk_ra1 = '0; chk_ra2 = '0;
    #1;
    chk("rst_ready0", 32'(req_ready), 32'd0);
    tick();
    chk("rst_ready1", 32'(req_ready), 32'd0);
    chk("rst_we",     32'(rf_we), 32'd0);
    chk("rst_wa",     32'(rf_wa), 32'd0);
    chk("rst_wd",     rf_wd, 32'd0);
    chk("rst_ptr",    ptr(), 32'd0);
    tick();
    rst = 1'b0; req_valid = '0;
    #1;
    chk("post_rst_we",    32'(rf_we), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd0);

    // Single requester.
    set_req(1, 6'd5, 32'hDEADBEEF); req_valid = 3'b010;
    #1 chk("single_ready", 32'(req_ready), 32'b010);
    tick(); req_valid = '0;
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_wa", 32'(rf_wa), 32'd5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    chk("single_ptr", ptr(), 32'd2);
    tick();
    chk("single_rf", rf_mem[5], 32'hDEADBEEF);
    chk("single_idle_we", 32'(rf_we), 32'd0);

    // Move pointer back to 0 via requester 2, then full contention.
    set_req(2, 6'd1, 32'h0); req_valid = 3'b100;
    tick(); req_valid = '0;
    chk("wrap_ptr", ptr(), 32'd0);
    for (int i = 0; i < int'(N); i++) set_req(i, AW'(i + 2), 32'(i + 32'h100));
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_g = N'(1) << (c % 3);
      #1 chk($sformatf("rr_gnt%0d", c), 32'(req_ready), 32'(exp_g));
      chk($sformatf("rr_onehot%0d", c), 32'($onehot(req_ready)), 32'd1);
      tick();
    end
    for (int c = 0; c < 4 && req_valid != '0; c++) begin
      rdy_s = req_ready;
      tick();
      req_valid = req_valid & ~rdy_s;
    end
    chk("drain_done", 32'(req_valid), 32'd0);
    chk("drain_ptr", ptr(), 32'd0);

    // Forwarding.
    set_req(0, 6'd10, 32'h12345678); req_valid = 3'b001;
    tick(); req_valid = '0;
    chk_ra1 = 6'd10; chk_ra2 = 6'd11;
    #1;
    chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
    chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
    chk("fwd_data", fwd_data, 32'h12345678);
    tick();
    chk("fwd_hit1_idle", 32'(fwd_hit1), 32'd0);

    // wb_en gating (pointer at 1).
    wb_en = 1'b0; set_req(0, 6'd12, 32'hA5A5A5A5); req_valid = 3'b001;
    #1 chk("gate_ready", 32'(req_ready), 32'd0);
    tick();
    chk("gate_ptr", ptr(), 32'd1);
    chk("gate_we", 32'(rf_we), 32'd0);
    wb_en = 1'b1;
    #1 chk("ungate_ready", 32'(req_ready), 32'b001);
    tick(); req_valid = '0;
    chk("ungate_wa", 32'(rf_wa), 32'd12);
    chk("ungate_ptr", ptr(), 32'd1);

    // Same address from two requesters: req1 granted first, req0 last wins.
    set_req(0, 6'd7, 32'hBBBB0000); set_req(1, 6'd7, 32'hAAAA1111); req_valid = 3'b011;
    #1 chk("same_first", 32'(req_ready), 32'b010);
    tick(); req_valid = 3'b001;
    #1 chk("same_second", 32'(req_ready), 32'b001);
    tick(); req_valid = '0;
    tick();
    chk("same_rf", rf_mem[7], 32'hBBBB0000);

    // Address 0 is an ordinary register.
    set_req(2, 6'd0, 32'hCAFEF00D); req_valid = 3'b100;
    tick(); req_valid = '0;
    chk("a0_we", 32'(rf_we), 32'd1);
    chk("a0_wa", 32'(rf_wa), 32'd0);
    tick();
    chk("a0_rf", rf_mem[0], 32'hCAFEF00D);

    // Mid-operation reset in the grant cycle (pointer moved to 1 first).
    set_req(0, 6'd21, 32'h11111111); req_valid = 3'b001;
    tick(); req_valid = 3'b010; set_req(1, 6'd20, 32'hBAD0BAD0); rst = 1'b1;
    #1 chk("mid_ready", 32'(req_ready), 32'd0);
    tick(); rst = 1'b0; req_valid = '0;
    chk("mid_we", 32'(rf_we), 32'd0);
    chk("mid_ptr", ptr(), 32'd0);
    tick();
    chk("mid_rf20", rf_mem[20], 32'd0);
    chk("mid_rf21", rf_mem[21], 32'h11111111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (WE1/WA/WD) between NUM_REQ write-back requesters, e.g. ALU, load unit and multiply unit.
- Round-robin grant, one write per cycle, registered output stage driving the register file.
- Forwarding compare for two read addresses, so a value granted but not yet written is still visible to readers.
- Sits between the execute/memory write-back sources and the 64x32 register file.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- ADDR_W, 6, register address width (64 registers).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- wb_en  input  1  global write-back enable; 0 = no grants issued.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  per-requester destination register; slice i belongs to requester i.
- req_data  input  NUM_REQ*DATA_W  per-requester write data; slice i belongs to requester i.
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs on valid&ready.
- rf_we  output  1  register file write enable.
- rf_wa  output  ADDR_W  register file write address.
- rf_wd  output  DATA_W  register file write data.
- chk_ra1  input  ADDR_W  read address 1 to check against the pending write.
- chk_ra2  input  ADDR_W  read address 2 to check against the pending write.
- fwd_hit1  output  1  chk_ra1 matches the pending write.
- fwd_hit2  output  1  chk_ra2 matches the pending write.
- fwd_data  output  DATA_W  pending write data (equals rf_wd).

Behaviour:
- Reset (rst=1 at posedge):
  - rf_we=0, rf_wa=0, rf_wd=0, rr_ptr=0.
  - req_ready=0 combinationally whenever rst=1.
  - rst mid-operation drops any pending output write; no write is issued the cycle after rst.
- Arbitration (combinational):
  - When wb_en=1 and rst=0, scan requesters from rr_ptr upward, modulo NUM_REQ.
  - The first with req_valid=1 gets req_ready=1.
  - At most one ready bit is high. No valid requests gives req_ready=0.
- Pointer update:
  - On a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ.
  - rr_ptr holds when there is no transfer.
- Output stage: 1-cycle latency.
  - On a transfer: rf_we<=1, rf_wa<=req_addr[g], rf_wd<=req_data[g].
  - Otherwise rf_we<=0, and rf_wa/rf_wd hold their values.
  - The register file commits at the following posedge, so request-to-architectural-state latency is 2 edges.
- Forwarding:
  - fwd_hitN = rf_we & (chk_raN == rf_wa), combinational.
  - fwd_data = rf_wd.
- Requester protocol:
  - req_valid/addr/data stay stable while valid=1 and ready=0.
  - Deasserting valid without a transfer is illegal. The bench asserts this.
- Same-address writes from two requesters: each is serviced in grant order. The last granted value wins in the register file.
- Address 0 gets no special treatment; it is written like any other register.
- wb_en=0: no grants, rr_ptr frozen. An output write already in the stage still completes.
- Back-to-back: a requester holding valid continuously is granted once every NUM_REQ cycles when all requesters contend, and every cycle when it is alone.

Decomposition:
- regfile_pkg holds:
  - constants REG_ADDR_W=6, REG_DATA_W=32, NUM_REGS=64;
  - typedef wb_req_t struct {addr, data};
  - function rr_next(idx, n).
- Sub-module rr_arbiter (parameter N): inputs req[N], en, clk, rst; outputs one-hot gnt[N], gnt_idx. It owns rr_ptr.
- The top level owns the output stage and the forwarding compare.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all valid=1 -> req_ready=0 throughout, and rf_we=0 in the cycle after rst falls.
- Single requester: req1 valid, addr=5, data=0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; the register file reads 0xDEADBEEF from reg 5 one cycle later.
- Full contention: all 3 valid for 6 cycles starting at rr_ptr=0 -> grants 0,1,2,0,1,2 with exactly one ready bit per cycle.
- Forwarding: grant a write of 0x12345678 to reg 10, then set chk_ra1=10 and chk_ra2=11 in the following cycle -> fwd_hit1=1, fwd_hit2=0, fwd_data=0x12345678.
- wb_en gating: wb_en=0 with req0 valid -> no ready and rr_ptr unchanged; raise wb_en -> req0 granted the same cycle.
- Mid-operation reset: assert rst in the cycle a grant occurs -> rf_we=0 next cycle, rr_ptr=0, and that write never reaches the register file.
